// File: rtl/srg_muldiv_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer: FSM state
// encodings, ALU opcodes and iteration counter type.
package srg_muldiv_pkg;

  typedef logic [2:0] state_t;

  // State encodings stay plain constants so legacy decode logic can reuse them.
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_PREP    = 3'd1;
  localparam state_t S_MUL     = 3'd2;
  localparam state_t S_DIV_CMP = 3'd3;
  localparam state_t S_DIV_SUB = 3'd4;
  localparam state_t S_FIX     = 3'd5;
  localparam state_t S_DONE    = 3'd6;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_GE  = 3'b111
  } alu_op_e;

  localparam int ITER_COUNT = 32;

  typedef logic [4:0] iter_t;

  localparam iter_t ITER_LAST = iter_t'(ITER_COUNT - 1);

endpackage

// File: rtl/srg_32Bit_ALU.sv
// 32-bit datapath ALU: AND, OR, ADD, SUB and unsigned GE (carry-out replicated
// across the result so any bit can be used as the flag).
module srg_32Bit_ALU
  import srg_muldiv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_control,
  output logic [31:0] result,
  output logic        Overflow
);

  logic        sub;
  logic [31:0] b_eff;
  logic [32:0] sum;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    sub      = alu_control[2];
    b_eff    = sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {32'b0, sub};
    result   = '0;
    Overflow = 1'b0;
    case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD, ALU_SUB: begin
        result   = sum[31:0];
        Overflow = (a[31] == b_eff[31]) && (sum[31] != a[31]);
      end
      ALU_GE:  result = {32{sum[32]}};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/srg_muldiv_seq.sv
// Multi-cycle MULT/DIV sequencer driving one private srg_32Bit_ALU; one bit per
// step. Define SRG_MULDIV_SIGNED_EN to add signed_op and the PREP/FIX states.
module srg_muldiv_seq
  import srg_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
`ifdef SRG_MULDIV_SIGNED_EN
  input  logic        signed_op,
`endif
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  state_t      state;
  state_t      iter_exit;
  iter_t       cnt;
  logic [31:0] mcand;
  logic        op_q;
  logic        ge;
`ifdef SRG_MULDIV_SIGNED_EN
  logic        sgn;
  logic        sa;
  logic        sb;
`endif

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  alu_op_e     alu_op;
  logic [31:0] alu_res;
  logic        alu_ovf_unused;
  logic [31:0] mul_sum;
  logic        mul_carry;

  srg_32Bit_ALU u_alu (
    .a           (alu_a),
    .b           (alu_b),
    .alu_control (alu_op),
    .result      (alu_res),
    .Overflow    (alu_ovf_unused)
  );

  always_comb begin
    alu_a  = hi;
    alu_b  = mcand;
    alu_op = ALU_ADD;
    case (state)
      S_DIV_CMP: begin
        alu_a  = {hi[30:0], lo[31]};
        alu_op = ALU_GE;
      end
      S_DIV_SUB: alu_op = ALU_SUB;
`ifdef SRG_MULDIV_SIGNED_EN
      // Phase 0 negates the a operand, phase 1 the b operand; their homes
      // swap between multiply (mcand=a, lo=b) and divide (lo=a, mcand=b).
      S_PREP: begin
        alu_a  = '0;
        alu_b  = (cnt[0] ^ op_q) ? lo : mcand;
        alu_op = ALU_SUB;
      end
      S_FIX: begin
        alu_a  = '0;
        alu_b  = cnt[0] ? hi : lo;
        alu_op = ALU_SUB;
      end
`endif
      default: ;
    endcase
  end

  // Carry out of hi+mcand rebuilt from the operand and sum sign bits.
  always_comb begin
    mul_sum   = hi;
    mul_carry = 1'b0;
    if (lo[0]) begin
      mul_sum   = alu_res;
      mul_carry = (hi[31] & mcand[31]) | ((hi[31] ^ mcand[31]) & ~alu_res[31]);
    end
  end

`ifdef SRG_MULDIV_SIGNED_EN
  assign iter_exit = sgn ? S_FIX : S_DONE;
`else
  assign iter_exit = S_DONE;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state is plain flops (no memories), so every register is reset.
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mcand       <= '0;
      op_q        <= 1'b0;
      ge          <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
`ifdef SRG_MULDIV_SIGNED_EN
      sgn         <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q        <= op;
            cnt         <= '0;
            div_by_zero <= op && (b == '0);
            if (!op) begin
              hi    <= '0;
              lo    <= b;
              mcand <= a;
            end else if (b == '0) begin
              hi    <= a;
              lo    <= '1;
              mcand <= b;
            end else begin
              hi    <= '0;
              lo    <= a;
              mcand <= b;
            end
`ifdef SRG_MULDIV_SIGNED_EN
            sgn <= signed_op;
            sa  <= signed_op & a[31];
            sb  <= signed_op & b[31];
            if (signed_op) state <= S_PREP;
            else
`endif
            state <= op ? ((b == '0) ? S_DONE : S_DIV_CMP) : S_MUL;
          end else begin
            state <= S_IDLE;
          end
        end
        S_MUL: begin
          {hi, lo} <= {mul_carry, mul_sum, lo[31:1]};
          cnt      <= cnt + 1'b1;
          if (cnt == ITER_LAST) state <= iter_exit;
        end
        S_DIV_CMP: begin
          {hi, lo} <= {hi[30:0], lo, 1'b0};
          // A bit shifted out of rem means rem already exceeds any divisor.
          ge       <= hi[31] | alu_res[0];
          state    <= S_DIV_SUB;
        end
        S_DIV_SUB: begin
          if (ge) begin
            hi    <= alu_res;
            lo[0] <= 1'b1;
          end
          cnt   <= cnt + 1'b1;
          state <= (cnt == ITER_LAST) ? iter_exit : S_DIV_CMP;
        end
`ifdef SRG_MULDIV_SIGNED_EN
        S_PREP: begin
          if (!div_by_zero) begin
            if (!cnt[0] && sa) begin
              if (op_q) lo <= alu_res;
              else      mcand <= alu_res;
            end
            if (cnt[0] && sb) begin
              if (op_q) mcand <= alu_res;
              else      lo <= alu_res;
            end
          end
          cnt <= cnt + 1'b1;
          if (cnt[0]) begin
            cnt   <= '0;
            state <= op_q ? (div_by_zero ? S_DONE : S_DIV_CMP) : S_MUL;
          end
        end
        S_FIX: begin
          if (!cnt[0]) begin
            if (sa ^ sb) lo <= alu_res;
          end else if (!op_q) begin
            // 64-bit negate: hi takes the borrow only when lo was zero.
            if (sa ^ sb) hi <= (lo == '0) ? alu_res : ~hi;
          end else if (sa) begin
            hi <= alu_res;
          end
          cnt <= cnt + 1'b1;
          if (cnt[0]) begin
            cnt   <= '0;
            state <= S_DONE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_srg_muldiv_seq.sv
// Directed self-checking bench for srg_muldiv_seq; the signed vectors run only
// when SRG_MULDIV_SIGNED_EN is defined.
module tb_srg_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic        sg_drv;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;
  int lat;

  srg_muldiv_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
`ifdef SRG_MULDIV_SIGNED_EN
    .signed_op   (sg_drv),
`endif
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic launch(input logic o, input logic [31:0] av, input logic [31:0] bv,
                        input logic s);
    op = o; a = av; b = bv; sg_drv = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the accept edge until done; optionally pulses start
  // in cycle k+poke. Returns at the negedge of the done cycle.
  task automatic wait_done(input int poke, output int n);
    @(negedge clk);
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      start = (poke != 0 && n == poke);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; sg_drv = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Largest unsigned product.
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mul_busy_k1", {31'b0, busy}, 32'd1);
    wait_done(0, lat);
    check("mul_ff_lat", lat, 32'd33);
    check("mul_ff_hi", hi, 32'hFFFF_FFFE);
    check("mul_ff_lo", lo, 32'h0000_0001);
    check("mul_ff_busy_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("mul_ff_done_pulse", {31'b0, done}, 32'd0);
    check("mul_ff_hold_lo", lo, 32'h0000_0001);

    launch(1'b1, 32'd100, 32'd7, 1'b0);
    wait_done(0, lat);
    check("div_100_7_lat", lat, 32'd65);
    check("div_100_7_lo", lo, 32'd14);
    check("div_100_7_hi", hi, 32'd2);
    check("div_100_7_dbz", {31'b0, div_by_zero}, 32'd0);

    launch(1'b1, 32'd5, 32'd0, 1'b0);
    wait_done(0, lat);
    check("dbz_lat", lat, 32'd1);
    check("dbz_flag", {31'b0, div_by_zero}, 32'd1);
    check("dbz_hi", hi, 32'd5);
    check("dbz_lo", lo, 32'hFFFF_FFFF);

    launch(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    wait_done(0, lat);
    check("div_big_lo", lo, 32'd1);
    check("div_big_hi", hi, 32'h7FFF_FFFE);
    check("div_big_dbz", {31'b0, div_by_zero}, 32'd0);

    // Multiply 3x5 with a stray start at k+10, then a back-to-back divide.
    launch(1'b0, 32'd3, 32'd5, 1'b0);
    op = 1'b1; a = 32'd9; b = 32'd4;
    wait_done(10, lat);
    check("mul_3_5_lat", lat, 32'd33);
    check("mul_3_5_hi", hi, 32'd0);
    check("mul_3_5_lo", lo, 32'd15);
    launch(1'b1, 32'd9, 32'd4, 1'b0);
    check("b2b_done_low", {31'b0, done}, 32'd0);
    check("b2b_busy_high", {31'b0, busy}, 32'd1);
    wait_done(0, lat);
    check("div_9_4_lat", lat, 32'd65);
    check("div_9_4_lo", lo, 32'd2);
    check("div_9_4_hi", hi, 32'd1);

    // Asynchronous reset in the middle of a multiply.
    launch(1'b0, 32'h1234_5678, 32'h0000_0009, 1'b0);
    repeat (12) @(negedge clk);
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(1'b0, 32'd6, 32'd7, 1'b0);
    wait_done(0, lat);
    check("mul_6_7_lat", lat, 32'd33);
    check("mul_6_7_lo", lo, 32'd42);
    check("mul_6_7_hi", hi, 32'd0);

`ifdef SRG_MULDIV_SIGNED_EN
    launch(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(0, lat);
    check("sdiv_lat", lat, 32'd69);
    check("sdiv_lo", lo, 32'hFFFF_FFFD);
    check("sdiv_hi", hi, 32'hFFFF_FFFF);

    launch(1'b0, 32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done(0, lat);
    check("smul_lat", lat, 32'd37);
    check("smul_hi", hi, 32'hFFFF_FFFF);
    check("smul_lo", lo, 32'hFFFF_FFF1);

    launch(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b1);
    wait_done(0, lat);
    check("sdbz_lat", lat, 32'd3);
    check("sdbz_hi", hi, 32'hFFFF_FFFB);
    check("sdbz_lo", lo, 32'hFFFF_FFFF);
    check("sdbz_flag", {31'b0, div_by_zero}, 32'd1);

    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(0, lat);
    check("umul_in_signed_lat", lat, 32'd33);
    check("umul_in_signed_hi", hi, 32'hFFFF_FFFE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/srg_muldiv_seq.md
# srg_muldiv_seq

Multi-cycle multiply/divide sequencer for the 32-bit MIPS datapath. It executes MULT/MULTU/DIV/DIVU-class operations by driving a single private `srg_32Bit_ALU` instance, iterating one bit per step, and returns a 64-bit `hi`/`lo` result pair. It sits beside the main ALU in the execute stage and feeds the HI/LO register file with a start/busy/done handshake.

## Interface
- No parameters; width fixed at 32 bits to match `srg_32Bit_ALU`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request. Sampled only in IDLE or DONE.
- `op` in 1: operation select, 0 = multiply, 1 = divide.
- `signed_op` in 1: signed operation select. Present only with `SRG_MULDIV_SIGNED_EN`.
- `a` in 32: multiplicand or dividend. Sampled on the accepted `start`.
- `b` in 32: multiplier or divisor. Sampled on the accepted `start`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid.
- `hi` out 32: product[63:32] or remainder.
- `lo` out 32: product[31:0] or quotient.
- `div_by_zero` out 1: last divide had `b`==0. Valid with `done`; held until the next accept.

## Operation
- **States:** IDLE, PREP (signed only), MUL, DIV_CMP, DIV_SUB, FIX (signed only), DONE.
- **ALU opcodes:** ADD=010, SUB=110, GE=111. GE yields all-ones when A>=B unsigned, via replicated carryout.
- **Accept:** a `start` in IDLE or DONE latches `a`, `b`, `op` (and `signed_op`). The sequencer then goes to PREP (signed) or directly to MUL/DIV.
- **Multiply** (shift-add, 32 MUL cycles):
  - Init: `hi`=0, `lo`=`b`, mcand=`a`.
  - Each cycle, if `lo[0]`: sum = ALU ADD(`hi`, mcand). Carry is recovered locally as (`hi[31]`&mcand[31]) | ((`hi[31]`^mcand[31]) & ~sum[31]).
  - Otherwise sum=`hi`, carry=0.
  - Then {`hi`,`lo`} = {carry, sum, `lo[31:1]`}.
- **Divide** (restoring, 32 iterations, each DIV_CMP then DIV_SUB):
  - Init: rem=0, quot=`a`.
  - DIV_CMP: {rem,quot} shifted left by 1; ALU GE(rem, divisor) is registered as ge.
  - DIV_SUB: if ge, rem = ALU SUB(rem, divisor) and quot[0]=1.
  - No 33-bit remainder case exists: the partial dividend stays below 2^31 before the final shift.
  - End state: `hi`=rem, `lo`=quot.
- **Divide by zero:** `b`==0 on accept skips iteration and goes straight to DONE. Result: `hi`=`a`, `lo`=32'hFFFF_FFFF, `div_by_zero`=1.
- **`start` while busy:** ignored, no queuing.
- **Result hold:** `hi`/`lo` hold their values from DONE until the next accept.
- **Reset mid-operation:** immediate return to IDLE. `busy`, `done`, `div_by_zero` = 0; `hi`, `lo` = 0.

## Timing
- **Reset values:** `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0.
- **Start reference:** `start` accepted at edge k.
  - `busy` is high from cycle k+1 through the last iteration cycle.
  - `busy` is low in the DONE cycle.
- **Unsigned latency (`done` high in cycle):**
  - Multiply: k+33.
  - Divide: k+65.
  - Divide by zero: k+1.
- **Signed latency:** PREP adds 2 cycles and FIX adds 2 cycles. Multiply k+37, divide k+69. Divide by zero is k+3 (PREP runs, FIX skipped).
- **Back-to-back:** a `start` in the DONE cycle is accepted. `done` deasserts next cycle and `busy` rises.
- **Done pulse:** `done` is exactly one cycle per accepted operation.

## Configuration
- **`SRG_MULDIV_SIGNED_EN` defined:**
  - Adds the `signed_op` port and the PREP/FIX states.
  - PREP: negates `a` then `b` when negative, using ALU SUB(0,x). Records sa, sb.
  - FIX, multiply: if sa^sb, `lo` = SUB(0,`lo`); `hi` = `lo`==0 ? SUB(0,`hi`) : ~`hi`.
  - FIX, divide: quotient negated if sa^sb; remainder negated if sa.
  - With `signed_op`=0, behaviour and latency match unsigned.
- **Not defined:** unsigned only. No `signed_op` port, no PREP/FIX logic.

## Structure
- **Package `srg_muldiv_pkg`:** state enum, ALU opcode constants (ALU_ADD, ALU_SUB, ALU_GE, ALU_AND=000, ALU_OR=001), ITER_COUNT=32, 5-bit iteration counter type.
- **Sub-module:** one `srg_32Bit_ALU` instance; its `Overflow` output is unused. All add/sub/compare goes through it. Shifts, carry recovery, inversion and the counter stay in sequencer logic.

## Test plan
- Unsigned multiply `a`=`b`=32'hFFFF_FFFF -> `hi`=32'hFFFF_FFFE, `lo`=32'h0000_0001, `done` at k+33.
- Unsigned divide 100/7 -> `lo`=14, `hi`=2, `div_by_zero`=0, `done` at k+65.
- Divide `a`=5, `b`=0 -> `div_by_zero`=1, `hi`=5, `lo`=32'hFFFF_FFFF, `done` at k+1.
- Multiply 3×5 with `start` re-asserted at k+10, then a back-to-back divide 9/4 started in the DONE cycle:
  - The k+10 `start` is ignored; the multiply gives `hi`=0, `lo`=15.
  - The divide gives `lo`=2, `hi`=1.
- `rst_n` low at k+12 of a multiply -> all outputs 0 asynchronously. A following multiply 6×7 gives `lo`=42.
- With `SRG_MULDIV_SIGNED_EN`:
  - Signed -7/2 -> `lo`=32'hFFFF_FFFD, `hi`=32'hFFFF_FFFF, `done` at k+69.
  - Signed -3×5 -> `hi`=32'hFFFF_FFFF, `lo`=32'hFFFF_FFF1, `done` at k+37.
